// File: rtl/tamagotchi_btn_conditioner.sv
// Button front end for the tamagotchi game FSM: sync, debounce, stat pulses
// and long-press pulses on reset/test. Optional macro: BTN_AUTOREPEAT_EN.
//
// Ports:
//   clk, reset          : 50 MHz clock, async active-high reset
//   raw_salud..raw_test : raw board pins, polarity set by ACTIVE_LOW
//   btn_salud..btn_test : active-high command pulses, PULSE_CYCLES wide
//   hold_active         : reset or test is in its hold-count phase
module tamagotchi_btn_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 250000000,
  parameter int PULSE_CYCLES      = 3750000,
  parameter int REPEAT_CYCLES     = 25000000,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_salud,
  input  logic raw_energia,
  input  logic raw_hambre,
  input  logic raw_diversion,
  input  logic raw_reset,
  input  logic raw_test,
  output logic btn_salud,
  output logic btn_energia,
  output logic btn_hambre,
  output logic btn_diversion,
  output logic btn_reset,
  output logic btn_test,
  output logic hold_active
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ?
                      $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LW = (LONG_PRESS_CYCLES > 1) ?
                      $clog2(LONG_PRESS_CYCLES) : 1;
  localparam int PW = (PULSE_CYCLES > 1) ?
                      $clog2(PULSE_CYCLES) : 1;

  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LP_MAX = LW'(LONG_PRESS_CYCLES - 1);
  localparam logic [PW-1:0] PU_MAX = PW'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_FIRE,
    S_WAIT
  } lp_state_e;

  // Channel order: {test, reset, diversion, hambre, energia, salud}
  logic [5:0] raw_v;
  logic [5:0] pin_v;
  logic [5:0] sync1_q;
  logic [5:0] sync2_q;
  logic [5:0] stable_q;
  logic [5:0] stable_d;
  logic [3:0] stable_prev_q;
  logic [3:0] rise_q;
  logic [3:0] pulse_v;
  logic       lp_fire;

  assign raw_v = {raw_test, raw_reset, raw_diversion,
                  raw_hambre, raw_energia, raw_salud};
  assign pin_v = (ACTIVE_LOW != 0) ? ~raw_v : raw_v;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      rise_q        <= '0;
    end else begin
      sync1_q       <= pin_v;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q[3:0];
      rise_q        <= stable_q[3:0] & ~stable_prev_q;
    end
  end

  for (genvar i = 0; i < 6; i++) begin : g_db
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;
    logic          stb_d;

    always_comb begin
      cnt_d = cnt_q;
      stb_d = stable_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d = '0;
      end else if (cnt_q == DB_MAX) begin
        cnt_d = '0;
        stb_d = ~stable_q[i];
      end else begin
        cnt_d = cnt_q + DW'(1);
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end

    assign stable_d[i] = stb_d;
  end

  for (genvar i = 0; i < 4; i++) begin : g_stat
    logic [PW-1:0] pcnt_q;
    logic          pulse_q;
    logic          start;

`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 1) ?
                        $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] RP_MAX = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rcnt_q;
    logic          armed_q;
    logic          rep;

    // Repeats only follow a press whose first pulse was accepted.
    assign rep   = armed_q & stable_q[i] & (rcnt_q == RP_MAX);
    assign start = (rise_q[i] | rep) & ~pulse_q & ~lp_fire;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rcnt_q  <= '0;
        armed_q <= 1'b0;
      end else if (start) begin
        rcnt_q  <= '0;
        armed_q <= 1'b1;
      end else if (!stable_q[i]) begin
        rcnt_q  <= '0;
        armed_q <= 1'b0;
      end else if (armed_q && rcnt_q != RP_MAX) begin
        rcnt_q  <= rcnt_q + RW'(1);
      end
    end
`else
    assign start = rise_q[i] & ~pulse_q & ~lp_fire;
`endif

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pulse_q <= 1'b0;
        pcnt_q  <= '0;
      end else if (pulse_q) begin
        if (pcnt_q == PU_MAX) pulse_q <= 1'b0;
        else                  pcnt_q  <= pcnt_q + PW'(1);
      end else if (start) begin
        pulse_q <= 1'b1;
        pcnt_q  <= '0;
      end
    end

    assign pulse_v[i] = pulse_q;
  end

  assign btn_salud     = pulse_v[0];
  assign btn_energia   = pulse_v[1];
  assign btn_hambre    = pulse_v[2];
  assign btn_diversion = pulse_v[3];

  lp_state_e     rs_q, rs_d, rs_nx;
  lp_state_e     ts_q, ts_d, ts_nx;
  logic [LW-1:0] rh_q, rh_d, th_q, th_d;
  logic [PW-1:0] rf_q, rf_d, tf_q, tf_d;

  function automatic lp_state_e lp_next(
    input lp_state_e s,
    input logic      pressed,
    input logic      hold_done,
    input logic      fire_done
  );
    lp_state_e n;
    n = s;
    unique case (s)
      S_IDLE: if (pressed) n = S_HOLD;
      S_HOLD: begin
        if (!pressed)      n = S_IDLE;
        else if (hold_done) n = S_FIRE;
      end
      S_FIRE: if (fire_done) n = S_WAIT;
      S_WAIT: if (!pressed)  n = S_IDLE;
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_q <= S_IDLE;
      ts_q <= S_IDLE;
      rh_q <= '0;
      th_q <= '0;
      rf_q <= '0;
      tf_q <= '0;
    end else begin
      rs_q <= rs_d;
      ts_q <= ts_d;
      rh_q <= rh_d;
      th_q <= th_d;
      rf_q <= rf_d;
      tf_q <= tf_d;
    end
  end

  always_comb begin
    rs_nx = lp_next(rs_q, stable_q[4], rh_q == LP_MAX,
                    rf_q == PU_MAX);
    ts_nx = lp_next(ts_q, stable_q[5], th_q == LP_MAX,
                    tf_q == PU_MAX);
    rs_d  = rs_nx;
    ts_d  = ts_nx;
    // Same-cycle long presses: reset wins, test is consumed silently.
    if (rs_q == S_HOLD && rs_nx == S_FIRE &&
        ts_q == S_HOLD && ts_nx == S_FIRE) begin
      ts_d = S_WAIT;
    end
    rh_d = (rs_q == S_HOLD && rh_q != LP_MAX) ?
           rh_q + LW'(1) : '0;
    th_d = (ts_q == S_HOLD && th_q != LP_MAX) ?
           th_q + LW'(1) : '0;
    rf_d = (rs_q == S_FIRE && rf_q != PU_MAX) ?
           rf_q + PW'(1) : '0;
    tf_d = (ts_q == S_FIRE && tf_q != PU_MAX) ?
           tf_q + PW'(1) : '0;
  end

  always_comb begin
    btn_reset   = (rs_q == S_FIRE);
    btn_test    = (ts_q == S_FIRE);
    hold_active = (rs_q == S_HOLD) | (ts_q == S_HOLD);
    lp_fire     = btn_reset | btn_test;
  end

endmodule
